mult_seq_32: RTL

//  Iterative 32x32 unsigned shift-add multiplier; ALU-side consumer of RC_ADD_SUB_32.

---
 rtl/mult_seq_32_pkg.sv | 14 +
 rtl/mult_seq_32_adder.sv | 32 +++
 rtl/mult_seq_32.sv | 119 +++++++++++
 3 files changed

// File: rtl/mult_seq_32_pkg.sv
// Shared definitions for the iterative 32x32 unsigned shift-add multiplier.
// Holds the operand and counter widths and the FSM state encoding.
package mult_seq_32_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'b00,
        MULT_RUN  = 2'b01,
        MULT_DONE = 2'b10
    } multState_t;

endpackage

// File: rtl/mult_seq_32_adder.sv
// Ripple-carry 32-bit adder/subtractor.
// Ports:
//   a, b      operands
//   snA       0 = add (a + b), 1 = subtract (a - b, two's complement)
//   sum       result bits
//   carryOut  carry out of the MSB (the 33rd sum bit in add mode)
module mult_seq_32_adder
    import mult_seq_32_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             snA,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    // Bit-serial ripple; subtract inverts b and injects a carry-in of 1.
    always_comb begin : rippleChain
        logic carry;
        logic bEff;
        sum   = '0;
        carry = snA;
        bEff  = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bEff   = b[i] ^ snA;
            sum[i] = a[i] ^ bEff ^ carry;
            carry  = (a[i] & bEff) | (carry & (a[i] ^ bEff));
        end
        carryOut = carry;
    end

endmodule

// File: rtl/mult_seq_32.sv
// Iterative 32x32 unsigned shift-add multiplier producing a 64-bit product
// {HI,LO} in 32 iterations, one adder pass per iteration.
// Ports:
//   CLK    clock, rising edge
//   RST    asynchronous active-high reset
//   START  request, sampled only while idle
//   A      multiplicand, captured on an accepted START
//   B      multiplier, captured on an accepted START
//   BUSY   high while iterating and during the DONE cycle
//   DONE   one-cycle pulse; HI/LO hold the final product in that cycle
//   HI     product[63:32] (live partial product while BUSY)
//   LO     product[31:0]  (live partial product while BUSY)
module mult_seq_32
    import mult_seq_32_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    multState_t       state, nextState;
    logic [WIDTH-1:0] mReg, mNext;
    logic [WIDTH-1:0] pHi, pHiNext;
    logic [WIDTH-1:0] pLo, pLoNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             busyReg, busyNext;
    logic             doneReg, doneNext;

    logic [WIDTH-1:0] addSum;
    logic             addCarry;

    // Single adder: upper product half plus multiplicand, add mode only.
    mult_seq_32_adder uAdder (
        .a        (pHi),
        .b        (mReg),
        .snA      (1'b0),
        .sum      (addSum),
        .carryOut (addCarry)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= MULT_IDLE;
            mReg    <= '0;
            pHi     <= '0;
            pLo     <= '0;
            cnt     <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            state   <= nextState;
            mReg    <= mNext;
            pHi     <= pHiNext;
            pLo     <= pLoNext;
            cnt     <= cntNext;
            busyReg <= busyNext;
            doneReg <= doneNext;
        end
    end

    // Next-state, datapath update and next values of the registered flags.
    always_comb begin
        nextState = state;
        mNext     = mReg;
        pHiNext   = pHi;
        pLoNext   = pLo;
        cntNext   = cnt;
        busyNext  = 1'b0;
        doneNext  = 1'b0;

        unique case (state)
            MULT_IDLE: begin
                if (START) begin
                    mNext     = A;
                    pHiNext   = '0;
                    pLoNext   = B;
                    cntNext   = '0;
                    nextState = MULT_RUN;
                    busyNext  = 1'b1;
                end
            end
            MULT_RUN: begin
                busyNext = 1'b1;
                // Carry becomes the new MSB, so the 64-bit product never overflows.
                if (pLo[0]) begin
                    {pHiNext, pLoNext} = {addCarry, addSum, pLo[WIDTH-1:1]};
                end else begin
                    {pHiNext, pLoNext} = {1'b0, pHi, pLo[WIDTH-1:1]};
                end
                cntNext = cnt + CNT_W'(1);
                if (cnt == LAST_ITER) begin
                    nextState = MULT_DONE;
                    doneNext  = 1'b1;
                end
            end
            MULT_DONE: begin
                nextState = MULT_IDLE;
            end
            default: begin
                nextState = MULT_IDLE;
            end
        endcase
    end

    assign BUSY = busyReg;
    assign DONE = doneReg;
    assign HI   = pHi;
    assign LO   = pLo;

endmodule
